// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
//
// Signals:
//   byte_valid_i  stream source has a byte on byte_i
//   byte_i        stream byte
//   byte_ready_o  loader accepts a byte this cycle
//   imem_wr_en_o  one-cycle instruction-memory write strobe
//   imem_addr_o   write byte address
//   imem_wdata_o  write data
//
// Handshake: a byte transfers on the rising clk edge where byte_valid_i and
// byte_ready_o are both high. The source may raise or drop byte_valid_i at any
// cycle and hold gaps of any length. byte_ready_o depends only on loader state,
// never on byte_valid_i. imem_wr_en_o is a bare strobe with no back-pressure:
// the memory must take the write in the cycle it is asserted.
//
// Modports: master = stream source / memory side, slave = the loader.
interface imem_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        imem_wr_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;

  modport master (
    output byte_valid_i,
    output byte_i,
    input  byte_ready_o,
    input  imem_wr_en_o,
    input  imem_addr_o,
    input  imem_wdata_o
  );

  modport slave (
    input  byte_valid_i,
    input  byte_i,
    output byte_ready_o,
    output imem_wr_en_o,
    output imem_addr_o,
    output imem_wdata_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: the write side of the instruction memory.
// Takes a byte stream (4-byte little-endian word count N, N little-endian
// words, 1 XOR checksum byte), writes the words to consecutive word addresses
// from BASE_ADDR, and holds the core in reset until a checksum-valid image has
// been written.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bus         imem_loader_if.slave: byte stream in, imem write strobe out
//   reload_i    restart loading; honoured only in DONE or ERR
//   core_rst_o  active-high hold-reset to the core (low only in DONE)
//   done_o      image loaded and verified
//   error_o     load failed (oversized header or bad checksum)
//   state_dbg   current FSM state encoding (HDR=0 DATA=1 CHK=2 DONE=3 ERR=4)
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  input  logic          reload_i,
  output logic          core_rst_o,
  output logic          done_o,
  output logic          error_o,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q;   // byte position within header / current word
  logic [31:0] count_q;      // header word count, shifted in LSB first
  logic [31:0] word_idx_q;   // index k of the word being assembled
  logic [23:0] word_buf_q;   // first three bytes of the current word
  logic [7:0]  csum_q;       // XOR of all header and data bytes so far
  logic        wr_en_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        ready;
  logic        fire;
  logic        last_byte;
  logic [31:0] hdr_full;
  logic        last_word;

  assign fire      = bus.byte_valid_i & ready;
  assign last_byte = (byte_idx_q == 2'd3);
  // Bytes arrive LSB first, so the 4th byte becomes the top byte.
  assign hdr_full  = {bus.byte_i, count_q[31:8]};
  // count_q >= 1 whenever DATA is active, so the subtraction cannot wrap.
  assign last_word = (word_idx_q == count_q - 32'd1);

  // Next-state and handshake output.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      S_HDR: begin
        ready = 1'b1;
        if (fire && last_byte) begin
          if (hdr_full > 32'(MAX_WORDS)) state_d = S_ERR;
          else if (hdr_full == 32'd0)    state_d = S_CHK;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
        ready = 1'b1;
        if (fire && last_byte && last_word) state_d = S_CHK;
      end
      S_CHK: begin
        ready = 1'b1;
        if (fire) state_d = (bus.byte_i == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (reload_i) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR;
      byte_idx_q <= 2'd0;
      count_q    <= 32'd0;
      word_idx_q <= 32'd0;
      word_buf_q <= 24'd0;
      csum_q     <= 8'd0;
      wr_en_q    <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      unique case (state_q)
        S_HDR: begin
          if (fire) begin
            count_q    <= hdr_full;
            csum_q     <= csum_q ^ bus.byte_i;
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        S_DATA: begin
          if (fire) begin
            csum_q     <= csum_q ^ bus.byte_i;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (last_byte) begin
              // Write issues in the following cycle, overlapping the next
              // accepted byte, so the stream never stalls.
              wr_en_q    <= 1'b1;
              addr_q     <= BASE_ADDR + {word_idx_q[29:0], 2'b00};
              wdata_q    <= {bus.byte_i, word_buf_q};
              word_idx_q <= word_idx_q + 32'd1;
            end else begin
              word_buf_q <= {bus.byte_i, word_buf_q[23:8]};
            end
          end
        end
        S_CHK: ;
        S_DONE, S_ERR: begin
          if (reload_i) begin
            byte_idx_q <= 2'd0;
            count_q    <= 32'd0;
            word_idx_q <= 32'd0;
            word_buf_q <= 24'd0;
            csum_q     <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.imem_wr_en_o = wr_en_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_wdata_o = wdata_q;
  assign done_o           = (state_q == S_DONE);
  assign error_o          = (state_q == S_ERR);
  assign core_rst_o       = (state_q != S_DONE);
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic       clk;
  logic       rst;
  logic       reload_i;
  logic       core_rst_o;
  logic       done_o;
  logic       error_o;
  logic [2:0] state_dbg;

  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .reload_i   (reload_i),
    .core_rst_o (core_rst_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {addr, data} of each expected write, in order
  int          n_writes = 0;
  logic        prev_wr  = 1'b0;

  always @(negedge clk) begin
    if (bus.imem_wr_en_o === 1'b1) begin
      n_writes++;
      check("wr_pulse_width", {63'd0, prev_wr}, 64'd0);
      if (exp_q.size() == 0)
        check("wr_unexpected", {63'd0, bus.imem_wr_en_o}, 64'd0);
      else
        check("wr_addr_data", {bus.imem_addr_o, bus.imem_wdata_o}, exp_q.pop_front());
    end
    prev_wr = bus.imem_wr_en_o;
  end

  // ---------------- driver tasks ----------------
  logic [31:0] img_w[0:7];

  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid_i = 1'b0;
    reload_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // duty: percent chance per cycle that the byte is offered now.
  task automatic send_byte(input logic [7:0] b, input int duty);
    int t;
    while ($urandom_range(0, 99) >= duty) begin
      @(posedge clk); #1;
    end
    t = 0;
    while (!bus.byte_ready_o && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.byte_ready_o) check("byte_ready_timeout", {63'd0, bus.byte_ready_o}, 64'd1);
    bus.byte_valid_i = 1'b1;
    bus.byte_i = b;
    @(posedge clk); #1;
    bus.byte_valid_i = 1'b0;
    bus.byte_i = $urandom_range(0, 255);
  endtask

  task automatic send_word(input logic [31:0] w, input int duty);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], duty);
  endtask

  // Sends a complete n-word image from img_w; bad_csum flips the trailer's LSB.
  task automatic run_image(input int n, input int duty, input logic bad_csum);
    logic [7:0]  c;
    logic [31:0] hdr;
    c = 8'd0;
    hdr = 32'(n);
    for (int i = 0; i < 4; i++) c ^= hdr[8*i +: 8];
    send_word(hdr, duty);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) c ^= img_w[k][8*i +: 8];
      exp_q.push_back({BASE + 32'(4 * k), img_w[k]});
      send_word(img_w[k], duty);
    end
    send_byte(c ^ {7'd0, bad_csum}, duty);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done_o || error_o) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("end_reached", {63'd0, done_o | error_o}, 64'd1);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e);
    check({tag, "_done"},    {63'd0, done_o},           {63'd0, d});
    check({tag, "_error"},   {63'd0, error_o},          {63'd0, e});
    check({tag, "_core_rst"},{63'd0, core_rst_o},       {63'd0, ~d});
    check({tag, "_ready"},   {63'd0, bus.byte_ready_o}, {63'd0, ~(d | e)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    rst = 1'b1;
    reload_i = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    {63'd0, bus.byte_ready_o}, 64'd1);
    check("rst_wr_en",    {63'd0, bus.imem_wr_en_o}, 64'd0);
    check("rst_addr",     {32'd0, bus.imem_addr_o},  {32'd0, BASE});
    check("rst_wdata",    {32'd0, bus.imem_wdata_o}, 64'd0);
    check("rst_core_rst", {63'd0, core_rst_o},       64'd1);
    check("rst_done",     {63'd0, done_o},           64'd0);
    check("rst_error",    {63'd0, error_o},          64'd0);
    check("rst_state",    {61'd0, state_dbg},        64'd0);
    rst = 1'b0;

    // Two-word image, correct trailer (0x92).
    img_w[0] = 32'h0000_0013;
    img_w[1] = 32'h0010_0093;
    w0 = n_writes;
    run_image(2, 100, 1'b0);
    wait_end();
    check_status("good2", 1'b1, 1'b0);
    check("good2_writes", 64'(n_writes - w0), 64'd2);
    check("good2_q_empty", 64'(exp_q.size()), 64'd0);

    // Same image, trailer 0x93: writes happen, then error.
    do_reset();
    w0 = n_writes;
    run_image(2, 100, 1'b1);
    wait_end();
    check_status("badcs", 1'b0, 1'b1);
    check("badcs_writes", 64'(n_writes - w0), 64'd2);
    // Bytes offered in ERR must not be accepted or written.
    bus.byte_valid_i = 1'b1;
    repeat (8) begin
      bus.byte_i = $urandom_range(0, 255);
      @(posedge clk); #1;
    end
    bus.byte_valid_i = 1'b0;
    check("err_sticky", {63'd0, error_o}, 64'd1);
    check("err_no_writes", 64'(n_writes - w0), 64'd2);

    // Oversized header N=1025.
    do_reset();
    w0 = n_writes;
    send_word(32'd1025, 100);
    check_status("hdr_big", 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("hdr_big_writes", 64'(n_writes - w0), 64'd0);

    // Empty image, trailer 00.
    do_reset();
    w0 = n_writes;
    run_image(0, 100, 1'b0);
    wait_end();
    check_status("empty", 1'b1, 1'b0);
    check("empty_writes", 64'(n_writes - w0), 64'd0);

    // Single word with 30% valid duty.
    do_reset();
    img_w[0] = $urandom;
    w0 = n_writes;
    run_image(1, 30, 1'b0);
    wait_end();
    check_status("gappy", 1'b1, 1'b0);
    check("gappy_writes", 64'(n_writes - w0), 64'd1);

    // Reset after 6 data bytes: only word 0 may have been written.
    do_reset();
    img_w[0] = 32'h0000_0013;
    img_w[1] = 32'h0010_0093;
    w0 = n_writes;
    send_word(32'd2, 100);
    exp_q.push_back({BASE, img_w[0]});
    send_word(img_w[0], 100);
    send_byte(img_w[1][7:0], 100);
    send_byte(img_w[1][15:8], 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_writes", 64'(n_writes - w0), 64'd1);
    check("midrst_q_empty", 64'(exp_q.size()), 64'd0);
    check("midrst_state", {61'd0, state_dbg}, 64'd0);
    check_status("midrst", 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_late_wr", 64'(n_writes - w0), 64'd1);

    // Replay the full image.
    w0 = n_writes;
    run_image(2, 100, 1'b0);
    wait_end();
    check_status("replay", 1'b1, 1'b0);
    check("replay_writes", 64'(n_writes - w0), 64'd2);

    // reload_i after DONE: back to HDR with the core held, then a new image.
    reload_i = 1'b1;
    @(posedge clk); #1;
    reload_i = 1'b0;
    check_status("reload", 1'b0, 1'b0);
    check("reload_state", {61'd0, state_dbg}, 64'd0);
    for (int k = 0; k < 3; k++) img_w[k] = $urandom;
    w0 = n_writes;
    run_image(3, 70, 1'b0);
    wait_end();
    check_status("reload_img", 1'b1, 1'b0);
    check("reload_writes", 64'(n_writes - w0), 64'd3);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the write side of the instruction memory that the fetch unit reads.
- Accepts a byte stream (header, instruction words, checksum) and writes 32-bit words into instruction memory at consecutive word addresses starting at BASE_ADDR.
- Holds the core in reset until a complete, checksum-valid image is written, so the first fetch from address 0 sees loaded code.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first written word; must be 4-byte aligned.
- MAX_WORDS, 1024, maximum instruction words accepted; a header count above this is an error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_valid_i  input  1  byte_i holds a valid byte.
- byte_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte; transfer occurs when byte_valid_i & byte_ready_o at the clk edge.
- reload_i  input  1  restart loading; honoured only in DONE or ERR.
- imem_wr_en_o  output  1  one-cycle write strobe.
- imem_addr_o  output  32  write byte address.
- imem_wdata_o  output  32  write data.
- core_rst_o  output  1  active-high hold-reset to the core.
- done_o  output  1  image loaded and verified.
- error_o  output  1  load failed.

Behaviour:
- Interface (decided): one clock; reset is synchronous and active-high.
- Reset values: state=HDR; byte_ready_o=1; imem_wr_en_o=0; imem_addr_o=BASE_ADDR; imem_wdata_o=0; core_rst_o=1; done_o=0; error_o=0; all counters and the checksum = 0.
- Stream format: 4-byte word count N (little-endian), then N words of 4 bytes each (little-endian, first byte goes to [7:0]), then 1 checksum byte.
- Checksum: XOR of every header and data byte.
- State HDR:
  - Accept 4 bytes into count N.
  - On the 4th byte, if N > MAX_WORDS, go to ERR.
  - Otherwise, if N == 0, go to CHK.
  - Otherwise, go to DATA.
- State DATA:
  - Assemble bytes into a word; byte index wraps 3 to 0.
  - In the cycle after the 4th byte is accepted, drive imem_wr_en_o=1 for exactly 1 cycle, with imem_addr_o = BASE_ADDR + 4*k and imem_wdata_o = the assembled word, where k = word index from 0.
  - byte_ready_o stays 1 during the write cycle; stream bytes are accepted without bubbles.
  - After word N-1 is assembled, go to CHK; its write pulse occurs in the first CHK cycle.
- State CHK:
  - Accept 1 byte.
  - If it equals the running XOR (bytes before the trailer), go to DONE; otherwise go to ERR.
- State DONE:
  - byte_ready_o=0, done_o=1.
  - core_rst_o=0 starting the first cycle in DONE.
- State ERR:
  - byte_ready_o=0, error_o=1, core_rst_o=1.
  - No further writes occur.
- reload_i in DONE or ERR: next cycle, state=HDR with counters, checksum, done_o and error_o cleared, and core_rst_o=1. Ignored in other states.
- Address arithmetic: 32-bit, modulo 2^32 (no wrap possible within MAX_WORDS from an aligned base).
- Reset mid-load: abandons the image; no partial-word write is issued; the loader returns to reset values the next cycle.
- byte_valid_i low: the state holds; gaps of any length are allowed.
- The loader never writes outside BASE_ADDR .. BASE_ADDR + 4*(N-1).

Test Plan:
- Stream 02 00 00 00, 13 00 00 00, 93 00 10 00, trailer 92 -> writes (0x0, 0x00000013) and (0x4, 0x00100093); done_o=1, core_rst_o=0.
- Same image with trailer 93 -> both writes occur, then error_o=1, core_rst_o=1, byte_ready_o=0.
- Header 01 04 00 00 (N=1025, MAX_WORDS=1024) -> error_o=1 immediately after the 4th byte; zero writes.
- Header 00 00 00 00, trailer 00 -> no writes; done_o=1.
- Single-word image with a random byte_valid_i duty of 30% -> same single write and done as the gap-free case; imem_wr_en_o high exactly 1 cycle.
- rst asserted after 6 data bytes, then the full 2-word image replayed -> no write at address 0x4 before rst; the replayed image writes both words and completes; reload_i after DONE reasserts core_rst_o and accepts a new image.
